// File: rtl/rf_alu_ctrl.sv
// Multicycle IDLE/DECODE/EXEC/DONE controller driving the RF_ALU datapath for one execute cycle per instruction.
// Optional feature: define RF_ALU_CTRL_SHIFT_EN to decode op 1000 as shift-immediate.
module rf_alu_ctrl #(
  parameter int WIDTH   = 16,
  parameter int REGBITS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [15:0]        instr,
  input  logic               instrValid,
  output logic               instrReady,
  output logic               regWrite,
  output logic               shiftOrALU,
  output logic               alusrca,
  output logic               alusrcb,
  output logic               shiftType,
  output logic [3:0]         aluControl,
  output logic [REGBITS-1:0] regAddress1,
  output logic [REGBITS-1:0] regAddress2,
  output logic [WIDTH-1:0]   immediate,
  output logic [WIDTH-1:0]   shiftDirection,
  output logic               jumpEN,
  output logic               jalEN,
  output logic               ALUselect,
  output logic               done,
  output logic               illegal
);

  typedef enum logic [1:0] {IDLE, DECODE, EXEC, DONE} state_t;

  state_t state_q, state_d;
  logic [15:0] ir_q, ir_d;

  logic               reg_write_q, reg_write_d;
  logic               alusrca_q, alusrca_d;
  logic               alusrcb_q, alusrcb_d;
  logic [3:0]         alu_control_q, alu_control_d;
  logic [REGBITS-1:0] ra1_q, ra1_d;
  logic [REGBITS-1:0] ra2_q, ra2_d;
  logic [WIDTH-1:0]   imm_q, imm_d;
  logic               done_q, done_d;
  logic               illegal_q, illegal_d;

  logic [3:0] op, ext;
  logic       dec_legal, dec_write, dec_srcb;
  logic [3:0] dec_alu;
  logic [WIDTH-1:0] dec_imm;

  assign op  = ir_q[15:12];
  assign ext = ir_q[7:4];

  function automatic logic is_alu_code(input logic [3:0] v);
    return v inside {4'b0001, 4'b0010, 4'b0011, 4'b0101, 4'b1001, 4'b1011, 4'b1101};
  endfunction

`ifdef RF_ALU_CTRL_SHIFT_EN
  logic             dec_shift, dec_shift_type;
  logic [WIDTH-1:0] dec_sdir;
  logic             shift_or_alu_q, shift_or_alu_d;
  logic             shift_type_q, shift_type_d;
  logic [WIDTH-1:0] sdir_q, sdir_d;
`endif

  // Decode works from the held IR so later instr changes cannot disturb it.
  always_comb begin
    dec_legal = 1'b0;
    dec_write = 1'b0;
    dec_srcb  = 1'b0;
    dec_alu   = 4'b0000;
    dec_imm   = '0;
`ifdef RF_ALU_CTRL_SHIFT_EN
    dec_shift      = 1'b0;
    dec_shift_type = 1'b0;
    dec_sdir       = '0;
`endif
    if (op == 4'b0000 && is_alu_code(ext)) begin
      dec_legal = 1'b1;
      dec_alu   = ext;
      dec_write = (ext != 4'b1011);
    end else if (is_alu_code(op)) begin
      dec_legal = 1'b1;
      dec_alu   = op;
      dec_srcb  = 1'b1;
      dec_write = (op != 4'b1011);
      dec_imm   = {{(WIDTH-8){(op inside {4'b0101, 4'b1001, 4'b1011}) & ir_q[7]}}, ir_q[7:0]};
    end
`ifdef RF_ALU_CTRL_SHIFT_EN
    else if (op == 4'b1000 && ext[3:2] == 2'b00) begin
      dec_legal      = 1'b1;
      dec_write      = 1'b1;
      dec_shift      = 1'b1;
      dec_shift_type = ext[1];
      dec_sdir       = {{(WIDTH-5){ext[0]}}, ext[0], ir_q[3:0]};
    end
`endif
  end

  always_comb begin
    state_d       = state_q;
    ir_d          = ir_q;
    reg_write_d   = 1'b0;
    alusrca_d     = 1'b0;
    alusrcb_d     = 1'b0;
    alu_control_d = 4'b0000;
    ra1_d         = '0;
    ra2_d         = '0;
    imm_d         = '0;
    done_d        = 1'b0;
    illegal_d     = 1'b0;
`ifdef RF_ALU_CTRL_SHIFT_EN
    shift_or_alu_d = 1'b0;
    shift_type_d   = 1'b0;
    sdir_d         = '0;
`endif
    unique case (state_q)
      IDLE: begin
        if (instrValid) begin
          ir_d    = instr;
          state_d = DECODE;
        end
      end
      DECODE: begin
        state_d = EXEC;
        // Controls are loaded here so they are registered for the whole EXEC cycle.
        if (dec_legal) begin
          reg_write_d   = dec_write;
          alusrca_d     = 1'b1;
          alusrcb_d     = dec_srcb;
          alu_control_d = dec_alu;
          ra1_d         = ir_q[11:8];
          ra2_d         = ir_q[3:0];
          imm_d         = dec_imm;
`ifdef RF_ALU_CTRL_SHIFT_EN
          shift_or_alu_d = !dec_shift;
          shift_type_d   = dec_shift_type;
          sdir_d         = dec_sdir;
`endif
        end
      end
      EXEC: begin
        state_d   = DONE;
        done_d    = 1'b1;
        illegal_d = !dec_legal;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      ir_q          <= '0;
      reg_write_q   <= 1'b0;
      alusrca_q     <= 1'b0;
      alusrcb_q     <= 1'b0;
      alu_control_q <= 4'b0000;
      ra1_q         <= '0;
      ra2_q         <= '0;
      imm_q         <= '0;
      done_q        <= 1'b0;
      illegal_q     <= 1'b0;
`ifdef RF_ALU_CTRL_SHIFT_EN
      shift_or_alu_q <= 1'b0;
      shift_type_q   <= 1'b0;
      sdir_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      ir_q          <= ir_d;
      reg_write_q   <= reg_write_d;
      alusrca_q     <= alusrca_d;
      alusrcb_q     <= alusrcb_d;
      alu_control_q <= alu_control_d;
      ra1_q         <= ra1_d;
      ra2_q         <= ra2_d;
      imm_q         <= imm_d;
      done_q        <= done_d;
      illegal_q     <= illegal_d;
`ifdef RF_ALU_CTRL_SHIFT_EN
      shift_or_alu_q <= shift_or_alu_d;
      shift_type_q   <= shift_type_d;
      sdir_q         <= sdir_d;
`endif
    end
  end

  assign instrReady  = (state_q == IDLE) && !reset;
  assign regWrite    = reg_write_q;
  assign alusrca     = alusrca_q;
  assign alusrcb     = alusrcb_q;
  assign aluControl  = alu_control_q;
  assign regAddress1 = ra1_q;
  assign regAddress2 = ra2_q;
  assign immediate   = imm_q;
  assign done        = done_q;
  assign illegal     = illegal_q;
  assign jumpEN      = 1'b0;
  assign jalEN       = 1'b0;
  assign ALUselect   = 1'b0;

`ifdef RF_ALU_CTRL_SHIFT_EN
  assign shiftOrALU     = shift_or_alu_q;
  assign shiftType      = shift_type_q;
  assign shiftDirection = sdir_q;
`else
  // Without the shifter path the ALU result is always selected.
  assign shiftOrALU     = 1'b1;
  assign shiftType      = 1'b0;
  assign shiftDirection = '0;
`endif

endmodule

// File: tb/tb_rf_alu_ctrl.sv
// Scoreboard bench for rf_alu_ctrl: random and directed instructions checked against a decode-table model.
module tb_rf_alu_ctrl;

`ifdef RF_ALU_CTRL_SHIFT_EN
  localparam bit SHIFT_EN = 1'b1;
`else
  localparam bit SHIFT_EN = 1'b0;
`endif
  localparam logic SOR_DFLT = !SHIFT_EN;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [15:0] instr = '0;
  logic instrValid = 1'b0;
  logic instrReady, regWrite, shiftOrALU, alusrca, alusrcb, shiftType;
  logic [3:0] aluControl, regAddress1, regAddress2;
  logic [15:0] immediate, shiftDirection;
  logic jumpEN, jalEN, ALUselect, done, illegal;

  rf_alu_ctrl #(.WIDTH(16), .REGBITS(4)) dut (
    .clk(clk), .reset(reset), .instr(instr), .instrValid(instrValid),
    .instrReady(instrReady), .regWrite(regWrite), .shiftOrALU(shiftOrALU),
    .alusrca(alusrca), .alusrcb(alusrcb), .shiftType(shiftType),
    .aluControl(aluControl), .regAddress1(regAddress1), .regAddress2(regAddress2),
    .immediate(immediate), .shiftDirection(shiftDirection), .jumpEN(jumpEN),
    .jalEN(jalEN), .ALUselect(ALUselect), .done(done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct {
    bit illegal, write, sor, srcb, stype, chk_imm, chk_sdir;
    int alu, ra1, ra2;
    logic [15:0] imm, sdir;
    int acc;
  } exp_t;

  typedef struct packed {
    logic rw, sor, srca, srcb, stype;
    logic [3:0] alu, ra1, ra2;
    logic [15:0] imm, sdir;
    logic jmp, jal, asel, dn, ill;
  } snap_t;

  exp_t sb_q[$];

  // Reference decode straight from the instruction-set table.
  function automatic exp_t model(input logic [15:0] ins);
    exp_t e;
    int op, ext, v;
    e = '{default: 0};
    op  = int'(ins[15:12]);
    ext = int'(ins[7:4]);
    e.sor = 1;
    if (op == 0 && ext inside {1, 2, 3, 5, 9, 11, 13}) begin
      e.alu = ext;
      e.write = (ext != 11);
    end else if (op inside {1, 2, 3, 5, 9, 11, 13}) begin
      e.alu = op;
      e.srcb = 1;
      e.write = (op != 11);
      v = int'(ins[7:0]);
      if (op inside {5, 9, 11} && v >= 128) v = v - 256;
      e.imm = v[15:0];
      e.chk_imm = 1;
    end else if (SHIFT_EN && op == 8 && ext < 4) begin
      e.sor = 0;
      e.stype = (ext >= 2);
      v = (ext % 2) * 16 + int'(ins[3:0]);
      if (v >= 16) v = v - 32;
      e.sdir = v[15:0];
      e.chk_sdir = 1;
      e.write = 1;
    end else begin
      e.illegal = 1;
      e.sor = SOR_DFLT;
    end
    if (!e.illegal) begin
      e.ra1 = int'(ins[11:8]);
      e.ra2 = int'(ins[3:0]);
    end
    return e;
  endfunction

  function automatic snap_t sample();
    return '{rw: regWrite, sor: shiftOrALU, srca: alusrca, srcb: alusrcb, stype: shiftType,
             alu: aluControl, ra1: regAddress1, ra2: regAddress2, imm: immediate,
             sdir: shiftDirection, jmp: jumpEN, jal: jalEN, asel: ALUselect, dn: done, ill: illegal};
  endfunction

  // Nonzero whenever any control output departs from its idle value.
  function automatic logic [63:0] ctrl_vec(input snap_t s);
    return {11'd0, s.rw, s.sor ^ SOR_DFLT, s.srca, s.srcb, s.stype, s.alu, s.ra1, s.ra2,
            s.imm, s.sdir, s.jmp, s.jal, s.asel, s.ill};
  endfunction

  // Monitor: on every done pulse, compare the EXEC-cycle snapshot with the queued expectation.
  initial begin
    snap_t cur, p1, p2;
    exp_t e;
    int hist;
    hist = 0;
    p1 = '0;
    p2 = '0;
    forever begin
      @(negedge clk);
      cur = sample();
      if (reset) begin
        hist = 0;
      end else begin
        if (cur.dn) begin
          if (sb_q.size() == 0) begin
            check("unexpected_done", 64'd1, 64'd0);
          end else begin
            e = sb_q.pop_front();
            check("history", 64'(hist >= 2), 64'd1);
            check("latency", 64'(cyc - e.acc), 64'd2);
            check("illegal", 64'(cur.ill), 64'(e.illegal));
            check("decode_idle", ctrl_vec(p2), 64'd0);
            check("done_ctrl", ctrl_vec(cur) & ~64'd1, 64'd0);
            if (e.illegal) begin
              check("illegal_ctrl", ctrl_vec(p1), 64'd0);
            end else begin
              check("regWrite", 64'(p1.rw), 64'(e.write));
              check("shiftOrALU", 64'(p1.sor), 64'(e.sor));
              check("alusrca", 64'(p1.srca), 64'd1);
              check("alusrcb", 64'(p1.srcb), 64'(e.srcb));
              check("shiftType", 64'(p1.stype), 64'(e.stype));
              check("aluControl", 64'(p1.alu), 64'(e.alu));
              check("regAddress1", 64'(p1.ra1), 64'(e.ra1));
              check("regAddress2", 64'(p1.ra2), 64'(e.ra2));
              check("tied_low", 64'({p1.jmp, p1.jal, p1.asel, p1.ill}), 64'd0);
              if (e.chk_imm) check("immediate", 64'(p1.imm), 64'(e.imm));
              if (e.chk_sdir) check("shiftDirection", 64'(p1.sdir), 64'(e.sdir));
            end
          end
        end
        hist++;
      end
      p2 = p1;
      p1 = cur;
    end
  end

  int prev_acc = -100;

  task automatic issue(input logic [15:0] ins, input bit garbage, input bit b2b);
    int w;
    exp_t e;
    w = 0;
    @(negedge clk);
    while (!instrReady && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!instrReady) begin
      check("ready_timeout", 64'(instrReady), 64'd1);
    end else begin
      instr = ins;
      instrValid = 1'b1;
      @(posedge clk);
      #1;
      e = model(ins);
      e.acc = cyc;
      sb_q.push_back(e);
      if (b2b) check("throughput", 64'(cyc - prev_acc), 64'd4);
      prev_acc = cyc;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        check("busy_not_ready", 64'(instrReady), 64'd0);
        if (garbage) begin
          instr = 16'($urandom);
          instrValid = 1'($urandom);
        end
      end
    end
  endtask

  task automatic idle(input int n);
    instrValid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  logic [3:0] op_pool [0:8] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD, 4'h8};
  logic [3:0] ext_pool [0:6] = '{4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD};

  initial begin
    logic [15:0] r;
    int qw;
    // Reset state
    repeat (3) @(negedge clk);
    check("reset_ready", 64'(instrReady), 64'd0);
    check("reset_ctrl", ctrl_vec(sample()), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    reset = 1'b0;
    #1;
    check("ready_after_reset", 64'(instrReady), 64'd1);

    // Reset held two cycles during EXEC of an ADD aborts it
    @(negedge clk);
    instr = 16'h0351;
    instrValid = 1'b1;
    @(posedge clk);
    #1;
    instrValid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_exec_regwrite", 64'(regWrite), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_regwrite_drop", 64'(regWrite), 64'd0);
    check("abort_no_done", 64'({done, illegal}), 64'd0);
    check("abort_ready_low", 64'(instrReady), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_ready_high", 64'(instrReady), 64'd1);
    idle(4);

    // Directed cases: ADD held valid back to back, immediates, CMP, shift, illegal
    issue(16'h0351, 1'b0, 1'b0);
    issue(16'h0351, 1'b0, 1'b1);
    issue(16'h52F0, 1'b1, 1'b1);
    issue(16'h12F0, 1'b1, 1'b1);
    issue(16'h0BB4, 1'b1, 1'b1);
    issue(16'h8113, 1'b1, 1'b1);
    issue(16'h8127, 1'b1, 1'b1);
    issue(16'hF000, 1'b1, 1'b1);
    issue(16'hB080, 1'b1, 1'b1);
    idle(2);

    // Random instructions, biased toward legal encodings
    for (int n = 0; n < 150; n++) begin
      r = 16'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        r[15:12] = op_pool[$urandom_range(0, 8)];
        if (r[15:12] == 4'h0) r[7:4] = ext_pool[$urandom_range(0, 6)];
        if (r[15:12] == 4'h8) r[7:6] = 2'b00;
      end
      if ($urandom_range(0, 7) == 0) begin
        idle($urandom_range(1, 3));
        issue(r, 1'($urandom), 1'b0);
      end else begin
        issue(r, 1'($urandom), 1'b1);
      end
    end

    idle(1);
    qw = 0;
    while (sb_q.size() != 0 && qw < 20) begin
      @(negedge clk);
      qw++;
    end
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    idle(4);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rf_alu_ctrl.md
# rf_alu_ctrl

Multicycle controller that sequences the RF_ALU datapath (register file, ALU, shifter, result/PSR flops). It accepts one 16-bit instruction per valid/ready handshake, decodes it, and drives the datapath control lines for exactly one execute cycle. It then reports completion. It sits between the instruction source (testbench or future fetch unit) and the RF_ALU instance; the PC path of the datapath is held idle.

## Interface
- WIDTH, 16, datapath width; immediates are extended to WIDTH
- REGBITS, 4, register-address width; must be 4 to match the instruction fields
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- instr  in  16  instruction word; fields: [15:12] op, [11:8] Rdest, [7:4] ext, [3:0] Rsrc/imm-low
- instrValid  in  1  instr is valid
- instrReady  out  1  controller can accept an instruction (IDLE only)
- regWrite, shiftOrALU, alusrca, alusrcb, shiftType  out  1 each  datapath controls
- aluControl  out  4  ALU operation
- regAddress1, regAddress2  out  REGBITS  Rdest (read and write port), Rsrc
- immediate, shiftDirection  out  WIDTH  extended immediate; signed shift amount
- jumpEN, jalEN, ALUselect  out  1 each  tied to 0
- done  out  1  one-cycle pulse when an instruction retires
- illegal  out  1  valid with done; instruction was not executed

## Operation
- FSM states: IDLE, DECODE, EXEC, DONE. Transitions: IDLE→DECODE on instrValid&&instrReady (instr latched into an internal IR); DECODE→EXEC; EXEC→DONE; DONE→IDLE. No other transitions. instrValid is ignored outside IDLE.
- Decode (op / ext):
  - Op 0000 R-type, ext ∈ {0001 AND, 0010 OR, 0011 XOR, 0101 ADD, 1001 SUB, 1011 CMP, 1101 MOV}: aluControl=ext, alusrcb=0.
  - Op ∈ {0001, 0010, 0011, 0101, 1001, 1011, 1101} I-type: aluControl=op, alusrcb=1; imm8=instr[7:0].
    - Sign-extended for 0101/1001/1011.
    - Zero-extended for 0001/0010/0011/1101.
  - Op 1000 shift-immediate: ext[3:1]=000 logical (shiftType=0), 001 arithmetic (shiftType=1). shiftOrALU=0. shiftDirection = sign-extended {ext[0], instr[3:0]} (negative = right).
  - All non-shift ops: shiftOrALU=1.
- alusrca=1 for every legal op. regAddress1=Rdest, regAddress2=Rsrc.
- regWrite=1 in EXEC for legal ops except CMP/CMPI. CMP/CMPI update PSR only.
- Any other op/ext: illegal. No regWrite, datapath controls stay at defaults, and illegal=1 with done.
- Defaults (outside EXEC and for illegal): all control outputs 0.

## Timing
- Reset: state=IDLE. All outputs 0 except instrReady. instrReady = (state==IDLE) && !reset. Reset in any state aborts the instruction with no regWrite, done, or illegal.
- Accept at edge T. DECODE during T+1. Control outputs are registered and valid for the whole of EXEC (T+2). The datapath result/PSR flops capture at the end of T+2. done (and illegal) pulse high during T+3. instrReady is high again at T+4.
- Latency accept→done is 3 cycles. Throughput is one instruction per 4 cycles.
- regWrite is high for exactly one cycle per legal writing instruction. It never overlaps done.
- IR holds during DECODE..DONE; changes on instr after acceptance have no effect.

## Configuration
- RF_ALU_CTRL_SHIFT_EN defined: op 1000 decoded as above.
- Undefined: op 1000 is illegal, and shiftOrALU is constant 1.

## Test plan
- Reset held 2 cycles mid-EXEC of ADD → regWrite drops next cycle; no done; state IDLE; instrReady=1 after release.
- instr=0x0351 (ADD R3,R1), instrValid held 1 → EXEC: aluControl=0101, alusrcb=0, regAddress1=3, regAddress2=1, regWrite=1; done at T+3; next accept at T+4.
- instr=0x52F0 (ADDI R2,#-16) → immediate=0xFFF0, alusrcb=1, regWrite=1. instr=0x12F0 (ANDI) → immediate=0x00F0.
- instr=0x0BB4 (CMP R11,R4) → aluControl=1011, regWrite=0 throughout; done=1, illegal=0.
- instr=0x8113 (LSHI R1,#-13, macro on) → shiftOrALU=0, shiftType=0, shiftDirection=0xFFF3, regWrite=1. Same instr with macro off → illegal=1, no regWrite.
- instr=0xF000 → done=1 with illegal=1. instrValid toggled during DECODE/EXEC → ignored; exactly one done.
